// File: rtl/mac_sa_iter_pkg.sv
// Shared definitions for the iterative shift-add MAC: FSM state encoding,
// counter-width helper and the accumulator-width elaboration check.

// Elaboration-time guard: the accumulator must hold at least one full product.
`define MAC_ACC_WIDTH_CHECK(W, AW) \
  if ((AW) < 2 * (W)) begin : g_acc_width_check \
    $error("mac_sa_iter: ACC_WIDTH must be >= 2*WIDTH"); \
  end

package mac_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t MULT = 2'd1;
  localparam state_t ACC  = 2'd2;

  // Bits needed for a counter running 0..n-1.
  function automatic int cnt_w(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mac_sa_iter_if.sv
// Operand/result bundle of mac_sa_iter. The master side streams operand
// pairs and reads back the accumulator; the slave side is the MAC itself.

interface mac_sa_iter_if #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 2 * WIDTH + 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 acc_clr;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 done;
  logic                 ovf;
  logic                 busy;

  modport master (
    output in_valid, a, b, acc_clr,
    input  in_ready, acc_out, done, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, acc_clr,
    output in_ready, acc_out, done, ovf, busy
  );
endinterface

// File: rtl/mac_sa_iter_mult.sv
// Radix-2 shift-add multiplier core. A start pulse loads the operands, then
// exactly WIDTH iterations run (no early exit when the multiplier empties);
// last flags the final iteration so the owner can move on.

module shift_add_mult_iter
  import mac_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_w(WIDTH);

  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt;
  logic               run;

  assign last    = run && (cnt == CW'(WIDTH - 1));
  assign product = prod_q;

  // Load on start, then add the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      prod_q <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      a_sh   <= {{WIDTH{1'b0}}, a};
      b_sh   <= b;
      prod_q <= '0;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      if (b_sh[0]) prod_q <= prod_q + a_sh;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CW'(1);
      if (cnt == CW'(WIDTH - 1)) run <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_sa_iter.sv
// Iterative shift-add multiply-accumulate unit. Accepts one operand pair in
// IDLE, multiplies over WIDTH cycles, then clears-or-adds the product into a
// wide accumulator with a sticky overflow flag and a one-cycle done pulse.
// Build option: define SATURATE_EN to clamp the accumulator to all ones on
// overflow instead of wrapping modulo 2^ACC_WIDTH.

module mac_sa_iter
  import mac_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 2 * WIDTH + 8
) (
  input  logic            clk,
  input  logic            rst,
  mac_sa_iter_if.slave    bus
);

  `MAC_ACC_WIDTH_CHECK(WIDTH, ACC_WIDTH)

`ifdef SATURATE_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  state_t               state;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ovf_q;
  logic                 clr_reg;
  logic [ACC_WIDTH-1:0] acc_q;

  logic                 start;
  logic                 last;
  logic [2*WIDTH-1:0]   product;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [ACC_WIDTH:0]   sum;

  // Carry-out of the accumulate decides wrap versus clamp.
  function automatic logic [ACC_WIDTH-1:0] acc_limit(input logic [ACC_WIDTH:0] s);
    return (SAT_ON && s[ACC_WIDTH]) ? '1 : s[ACC_WIDTH-1:0];
  endfunction

  assign start    = (state == IDLE) && bus.in_valid && in_ready_q;
  assign acc_base = clr_reg ? '0 : acc_q;
  assign sum      = {1'b0, acc_base} + (ACC_WIDTH + 1)'(product);

  shift_add_mult_iter #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (bus.a),
    .b       (bus.b),
    .last    (last),
    .product (product)
  );

  // Control FSM plus accumulator, overflow and done registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      clr_reg    <= 1'b0;
      acc_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            clr_reg    <= bus.acc_clr;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= MULT;
          end
        end
        MULT: begin
          if (last) state <= ACC;
        end
        ACC: begin
          acc_q      <= acc_limit(sum);
          ovf_q      <= clr_reg ? sum[ACC_WIDTH] : (ovf_q | sum[ACC_WIDTH]);
          done_q     <= 1'b1;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ovf      = ovf_q;
  assign bus.acc_out  = acc_q;

endmodule

// File: tb/tb_mac_sa_iter.sv
// Bench for mac_sa_iter (WIDTH=8, ACC_WIDTH=16): directed scenarios plus
// randomized operand pairs against an arithmetic accumulator model.

module tb_mac_sa_iter;

  localparam int WIDTH = 8;
  localparam int ACC_W = 16;
  localparam longint ACC_MOD = 64'd1 << ACC_W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mac_sa_iter_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_W)) bus ();

  mac_sa_iter #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     errors = 0;
  int     checks = 0;
  longint acc_m  = 0;
  bit     ovf_m  = 1'b0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: acc = (clr ? 0 : acc) + a*b, overflow when the sum leaves ACC_W bits.
  task automatic model_apply(input int a, input int b, input bit clr);
    longint sum;
    bit     carry;
    sum   = (clr ? 64'd0 : acc_m) + longint'(a) * longint'(b);
    carry = (sum >= ACC_MOD);
    ovf_m = clr ? carry : (ovf_m | carry);
`ifdef SATURATE_EN
    acc_m = carry ? (ACC_MOD - 1) : sum;
`else
    acc_m = sum % ACC_MOD;
`endif
  endtask

  task automatic check_idle_outputs(input string tag, input longint exp_acc, input bit exp_ovf);
    check_val({tag, "_acc"},      longint'(bus.acc_out),  exp_acc);
    check_val({tag, "_done"},     longint'(bus.done),     0);
    check_val({tag, "_ovf"},      longint'(bus.ovf),      longint'(exp_ovf));
    check_val({tag, "_busy"},     longint'(bus.busy),     0);
    check_val({tag, "_in_ready"}, longint'(bus.in_ready), 1);
  endtask

  // Present a pair, wait (bounded) for acceptance, then scramble the inputs.
  task automatic start_op(input int a, input int b, input bit clr, input string tag);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = WIDTH'(a);
    bus.b        = WIDTH'(b);
    bus.acc_clr  = clr;
    for (int k = 0; k < 40; k++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check_val({tag, "_accept_timeout"}, 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = WIDTH'($urandom);
    bus.b        = WIDTH'($urandom);
    bus.acc_clr  = 1'($urandom);
  endtask

  // Called right after the acceptance edge; counts edges until done.
  task automatic wait_done(input string tag);
    bit seen;
    int lat;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check_val({tag, "_busy_mult"},  longint'(bus.busy),     1);
        check_val({tag, "_ready_mult"}, longint'(bus.in_ready), 0);
      end
      if (bus.done) begin
        seen = 1'b1;
        lat  = k - 1;
        break;
      end
    end
    if (!seen) begin
      check_val({tag, "_done_timeout"}, 0, 1);
    end else begin
      check_val({tag, "_latency"}, lat, WIDTH + 1);
      check_val({tag, "_acc"},     longint'(bus.acc_out), acc_m);
      check_val({tag, "_ovf"},     longint'(bus.ovf),     longint'(ovf_m));
    end
  endtask

  task automatic run_op(input int a, input int b, input bit clr, input string tag);
    start_op(a, b, clr, tag);
    model_apply(a, b, clr);
    wait_done(tag);
    @(negedge clk);
    check_val({tag, "_done_pulse"}, longint'(bus.done), 0);
  endtask

  initial begin
    int done_cnt;
    int ra;
    int rb;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.acc_clr  = 1'b0;

    // Reset state, then idle with random operand noise.
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 0, 1'b0);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bus.a = WIDTH'($urandom);
      bus.b = WIDTH'($urandom);
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check_idle_outputs("idle", 0, 1'b0);
    check_val("idle_no_done", done_cnt, 0);

    // Basic sequence.
    run_op(3, 5, 1'b1, "basic_3x5");
    run_op(255, 255, 1'b0, "basic_255x255_acc");
    run_op(2, 7, 1'b1, "basic_2x7");

    // Busy protection: a second pair is held valid throughout the first op.
    start_op(10, 10, 1'b1, "busy");
    bus.in_valid = 1'b1;
    bus.a        = WIDTH'(200);
    bus.b        = WIDTH'(200);
    bus.acc_clr  = 1'b1;
    model_apply(10, 10, 1'b1);
    wait_done("busy_first");
    check_val("busy_ready_at_done", longint'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model_apply(200, 200, 1'b1);
    wait_done("busy_second");
    @(negedge clk);

    // Overflow.
    run_op(255, 255, 1'b1, "ovf_first");
    run_op(255, 255, 1'b0, "ovf_second");
    run_op(1, 1, 1'b1, "ovf_clear");

    // Reset in the 4th MULT cycle discards the operation.
    start_op(200, 100, 1'b1, "rstmid");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    acc_m = 0;
    ovf_m = 1'b0;
    check_idle_outputs("rstmid", 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check_val("rstmid_no_done", done_cnt, 0);
    run_op(12, 12, 1'b1, "after_rst_12x12");

    // Zero multiplicand still takes the full iteration count.
    run_op(0, 255, 1'b1, "zero_a");

    // Random operations; accumulates dominate so overflow is exercised.
    for (int i = 0; i < 25; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      run_op(ra, rb, ($urandom_range(0, 3) == 0), $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
